// File: rtl/sweep_ping_controller_if.sv
// Result channel from the ping sequencer toward the range/display logic.
`timescale 1ns/1ps
interface sweep_ping_controller_if #(
   parameter int ANGLE_WIDTH  = 7,
   parameter int TOF_WIDTH    = 25,
   parameter int SAMPLE_WIDTH = 16,
   parameter int INDEX_WIDTH  = 2
);
   logic                    result_valid_out;
   logic                    result_ready_in;
   logic [ANGLE_WIDTH-1:0]  result_angle_out;
   logic [TOF_WIDTH-1:0]    result_tof_out;
   logic [SAMPLE_WIDTH-1:0] result_peak_out;
   logic [INDEX_WIDTH-1:0]  result_index_out;

   modport master (
      output result_valid_out, result_angle_out, result_tof_out,
             result_peak_out, result_index_out,
      input  result_ready_in
   );

   modport slave (
      input  result_valid_out, result_angle_out, result_tof_out,
             result_peak_out, result_index_out,
      output result_ready_in
   );
endinterface

// File: rtl/sweep_ping_controller.sv
// Sweep ping sequencer with hysteretic multi-echo detection; SWEEP_BOUNCE_EN selects a ping-pong sweep.
// Latency: an echo reaches the result head two clocks after its closing sample (or one clock after ADVANCE).
// Backpressure: results queue in a FIFO_DEPTH FIFO; when full a new result is dropped and overflow_out sticks.
`timescale 1ns/1ps
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_vld,
   output logic             in_rdy,
   input  logic [WIDTH-1:0] in_dat,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic [WIDTH-1:0] out_dat
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr;
   logic             full, do_push, do_pop;

   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign out_vld = (wr_ptr != rd_ptr);
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign in_rdy  = !full || out_rdy;
   assign do_push = in_vld && in_rdy;
   assign do_pop  = out_vld && out_rdy;
   assign out_dat = out_vld ? mem[rd_ptr[AW-1:0]] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= in_dat;
   end
endmodule

module sweep_ping_controller #(
   parameter int BURST_CYCLES  = 524288,
   parameter int BLANK_CYCLES  = 65536,
   parameter int LISTEN_CYCLES = 16252928,
   parameter int ANGLE_WIDTH   = 7,
   parameter int ANGLE_MIN     = -30,
   parameter int ANGLE_MAX     = 30,
   parameter int ANGLE_STEP    = 10,
   parameter int SAMPLE_WIDTH  = 16,
   parameter int HYST          = 256,
   parameter int MAX_ECHOES    = 4,
   parameter int FIFO_DEPTH    = 8,
   parameter int TOF_WIDTH     = $clog2(BURST_CYCLES + BLANK_CYCLES + LISTEN_CYCLES)
) (
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic                          enable_in,
   input  logic [SAMPLE_WIDTH-1:0]       threshold_in,
   input  logic [SAMPLE_WIDTH-1:0]       sample_in,
   input  logic                          sample_valid_in,
   output logic signed [ANGLE_WIDTH-1:0] beam_angle_out,
   output logic                          burst_start_out,
   output logic                          burst_active_out,
   output logic                          listening_out,
   output logic                          ping_done_out,
   output logic                          overflow_out,
   sweep_ping_controller_if.master       result_bus
);
   localparam int IDX_W = (MAX_ECHOES > 1) ? $clog2(MAX_ECHOES) : 1;
   localparam int CNT_W = $clog2(MAX_ECHOES + 1);
   localparam logic [TOF_WIDTH-1:0] BURST_END  = TOF_WIDTH'(BURST_CYCLES - 1);
   localparam logic [TOF_WIDTH-1:0] BLANK_END  = TOF_WIDTH'(BURST_CYCLES + BLANK_CYCLES - 1);
   localparam logic [TOF_WIDTH-1:0] LISTEN_END = TOF_WIDTH'(BURST_CYCLES + BLANK_CYCLES + LISTEN_CYCLES - 1);
   localparam logic [SAMPLE_WIDTH-1:0] HYST_V  = SAMPLE_WIDTH'(HYST);
   localparam logic [CNT_W-1:0]        MAX_E   = CNT_W'(MAX_ECHOES);
   localparam logic signed [ANGLE_WIDTH:0]   A_MIN_W = ANGLE_MIN[ANGLE_WIDTH:0];
   localparam logic signed [ANGLE_WIDTH:0]   A_MAX_W = ANGLE_MAX[ANGLE_WIDTH:0];
   localparam logic signed [ANGLE_WIDTH:0]   STEP_W  = ANGLE_STEP[ANGLE_WIDTH:0];
   localparam logic signed [ANGLE_WIDTH-1:0] A_MIN   = ANGLE_MIN[ANGLE_WIDTH-1:0];

   typedef enum logic [2:0] {S_IDLE, S_BURST, S_BLANK, S_LISTEN, S_ADVANCE} state_t;

   typedef struct packed {
      logic [ANGLE_WIDTH-1:0]  angle;
      logic [TOF_WIDTH-1:0]    tof;
      logic [SAMPLE_WIDTH-1:0] peak;
      logic [IDX_W-1:0]        index;
   } result_t;

   state_t                   state, state_nxt;
   logic                     ping_start;
   logic [TOF_WIDTH-1:0]     tof;
   logic signed [ANGLE_WIDTH:0]   angle_w, angle_up, angle_dn;
   logic signed [ANGLE_WIDTH-1:0] angle_nxt;

   logic                     echo_open, close_pend;
   logic [TOF_WIDTH-1:0]     echo_tof;
   logic [SAMPLE_WIDTH-1:0]  echo_peak, release_lvl;
   logic [CNT_W-1:0]         echo_cnt, echo_used;
   logic                     listen_smp, arm, release_hit, push_vld, push_rdy;
   result_t                  push_dat, head_dat;

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:    if (enable_in) state_nxt = S_BURST;
         S_BURST:   if (tof == BURST_END) state_nxt = S_BLANK;
         S_BLANK:   if (tof == BLANK_END) state_nxt = S_LISTEN;
         S_LISTEN:  if (tof == LISTEN_END) state_nxt = S_ADVANCE;
         S_ADVANCE: state_nxt = enable_in ? S_BURST : S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
      ping_start = (state_nxt == S_BURST) && (state != S_BURST);
   end

   // Status outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state            <= S_IDLE;
         tof              <= '0;
         burst_start_out  <= 1'b0;
         burst_active_out <= 1'b0;
         listening_out    <= 1'b0;
         ping_done_out    <= 1'b0;
      end else begin
         state            <= state_nxt;
         burst_start_out  <= ping_start;
         burst_active_out <= (state_nxt == S_BURST);
         listening_out    <= (state_nxt == S_LISTEN);
         ping_done_out    <= (state_nxt == S_ADVANCE);
         if (ping_start)            tof <= '0;
         else if (state != S_IDLE)  tof <= tof + 1'b1;
      end
   end

   assign angle_w  = {beam_angle_out[ANGLE_WIDTH-1], beam_angle_out};
   assign angle_up = angle_w + STEP_W;
   assign angle_dn = angle_w - STEP_W;

`ifdef SWEEP_BOUNCE_EN
   logic dir_down, dir_down_nxt;

   always_comb begin
      angle_nxt    = angle_up[ANGLE_WIDTH-1:0];
      dir_down_nxt = dir_down;
      if (!dir_down) begin
         if (angle_up > A_MAX_W) begin
            angle_nxt    = angle_dn[ANGLE_WIDTH-1:0];
            dir_down_nxt = 1'b1;
         end
      end else if (angle_dn < A_MIN_W) begin
         dir_down_nxt = 1'b0;
      end else begin
         angle_nxt = angle_dn[ANGLE_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)                  dir_down <= 1'b0;
      else if (state == S_ADVANCE) dir_down <= dir_down_nxt;
   end
`else
   always_comb begin
      angle_nxt = angle_up[ANGLE_WIDTH-1:0];
      if (angle_up > A_MAX_W) angle_nxt = A_MIN;
   end
`endif

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)                  beam_angle_out <= A_MIN;
      else if (state == S_ADVANCE) beam_angle_out <= angle_nxt;
   end

   assign release_lvl = (threshold_in > HYST_V) ? threshold_in - HYST_V : '0;
   assign listen_smp  = (state == S_LISTEN) && sample_valid_in;
   // A close waiting to be pushed already uses up one of this ping's echo slots.
   assign echo_used   = echo_cnt + CNT_W'(close_pend);
   assign arm         = listen_smp && !echo_open && (sample_in >= threshold_in) && (echo_used < MAX_E);
   assign release_hit = listen_smp && echo_open && (sample_in < release_lvl);
   assign push_vld    = close_pend || ((state == S_ADVANCE) && echo_open);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         echo_open  <= 1'b0;
         close_pend <= 1'b0;
         echo_tof   <= '0;
         echo_peak  <= '0;
         echo_cnt   <= '0;
      end else begin
         close_pend <= release_hit;
         if (ping_start) begin
            echo_open <= 1'b0;
            echo_cnt  <= '0;
         end else begin
            if (push_vld) echo_cnt <= echo_cnt + 1'b1;
            if (arm) begin
               echo_open <= 1'b1;
               echo_tof  <= tof;
               echo_peak <= sample_in;
            end else if (release_hit || (state == S_ADVANCE)) begin
               echo_open <= 1'b0;
            end else if (listen_smp && echo_open && (sample_in > echo_peak)) begin
               echo_peak <= sample_in;
            end
         end
      end
   end

   assign push_dat = '{angle: beam_angle_out, tof: echo_tof, peak: echo_peak,
                       index: echo_cnt[IDX_W-1:0]};

   sync_fifo #(
      .WIDTH ($bits(result_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_result_fifo (
      .clk     (clk_in),
      .rst     (rst_in),
      .in_vld  (push_vld),
      .in_rdy  (push_rdy),
      .in_dat  (push_dat),
      .out_vld (result_bus.result_valid_out),
      .out_rdy (result_bus.result_ready_in),
      .out_dat (head_dat)
   );

   assign result_bus.result_angle_out = head_dat.angle;
   assign result_bus.result_tof_out   = head_dat.tof;
   assign result_bus.result_peak_out  = head_dat.peak;
   assign result_bus.result_index_out = head_dat.index;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)                     overflow_out <= 1'b0;
      else if (push_vld && !push_rdy) overflow_out <= 1'b1;
   end
endmodule

// File: tb/tb_sweep_ping_controller.sv
// Bench for sweep_ping_controller: table-driven timing/sample schedule plus a result scoreboard.
`timescale 1ns/1ps
module tb_sweep_ping_controller;
   logic              clk_in = 1'b0;
   logic              rst_in, enable_in, sample_valid_in;
   logic [15:0]       threshold_in, sample_in;
   logic signed [6:0] beam_angle_out;
   logic              burst_start_out, burst_active_out, listening_out, ping_done_out, overflow_out;

   sweep_ping_controller_if #(.ANGLE_WIDTH(7), .TOF_WIDTH(5), .SAMPLE_WIDTH(16), .INDEX_WIDTH(1)) res ();

   sweep_ping_controller #(
      .BURST_CYCLES(4), .BLANK_CYCLES(2), .LISTEN_CYCLES(20), .HYST(2),
      .MAX_ECHOES(2), .FIFO_DEPTH(2)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in),
      .threshold_in(threshold_in), .sample_in(sample_in), .sample_valid_in(sample_valid_in),
      .beam_angle_out(beam_angle_out), .burst_start_out(burst_start_out),
      .burst_active_out(burst_active_out), .listening_out(listening_out),
      .ping_done_out(ping_done_out), .overflow_out(overflow_out), .result_bus(res)
   );

   always #5 clk_in = ~clk_in;

   typedef struct { int t; logic bs; logic ba; logic li; logic pd; } tv_t;
   typedef struct { int ping; int t; int val; logic vld; } smp_t;
   typedef struct { int ping; int tof; int peak; int idx; } res_t;
   typedef struct { int angle; int tof; int peak; int idx; } exp_t;

   tv_t  tv [9];
   smp_t sched [24];
   res_t exp_tab [7];
   exp_t exp_q [$];
   exp_t mon_e;

   int n_checks = 0, n_pass = 0;
   int cyc = 0, base = 0, cur_ping = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic int exp_angle(input int k);
      int i;
`ifdef SWEEP_BOUNCE_EN
      i = k % 12;
      if (i > 6) i = 12 - i;
`else
      i = k % 7;
`endif
      return -30 + 10 * i;
   endfunction

   task automatic step();
      @(posedge clk_in);
      #1;
      cyc++;
      sample_in = '0;
      sample_valid_in = 1'b0;
      foreach (sched[i])
         if (sched[i].ping == cur_ping && sched[i].t == cyc - base) begin
            sample_in = 16'(sched[i].val);
            sample_valid_in = sched[i].vld;
         end
   endtask

   task automatic run_to(input int t);
      while (cyc - base < t) step();
   endtask

   task automatic begin_ping(input int p);
      exp_t e;
      base = cyc;
      cur_ping = p;
      foreach (exp_tab[i])
         if (exp_tab[i].ping == p) begin
            e = '{exp_angle(p), exp_tab[i].tof, exp_tab[i].peak, exp_tab[i].idx};
            exp_q.push_back(e);
         end
      chk($sformatf("p%0d burst_start", p), burst_start_out, 1);
      chk($sformatf("p%0d angle", p), beam_angle_out, exp_angle(p));
   endtask

   // Scoreboard: compare the head at every accepted handshake.
   always @(negedge clk_in) begin
      if (!rst_in && res.result_valid_out && res.result_ready_in) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected result: angle %0d tof %0d with nothing expected",
                     $signed(res.result_angle_out), res.result_tof_out);
         end else begin
            mon_e = exp_q.pop_front();
            chk("res angle", $signed(res.result_angle_out), mon_e.angle);
            chk("res tof",   res.result_tof_out,   mon_e.tof);
            chk("res peak",  res.result_peak_out,  mon_e.peak);
            chk("res index", res.result_index_out, mon_e.idx);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_in = 1'b1; enable_in = 1'b0; threshold_in = 16'd10;
      sample_in = '0; sample_valid_in = 1'b0; res.result_ready_in = 1'b1;

      tv = '{'{0,1,1,0,0}, '{1,0,1,0,0}, '{3,0,1,0,0}, '{4,0,0,0,0}, '{5,0,0,0,0},
             '{6,0,0,1,0}, '{7,0,0,1,0}, '{25,0,0,1,0}, '{26,0,0,0,1}};
      sched = '{'{0,8,12,1}, '{0,9,15,1}, '{0,10,9,1}, '{0,11,7,1},
                '{1,7,11,1}, '{1,8,5,1}, '{1,10,13,1}, '{1,11,3,1}, '{1,14,14,1}, '{1,15,2,1},
                '{2,3,50,1}, '{2,5,50,1}, '{2,25,20,1}, '{3,10,40,0},
                '{4,8,12,1}, '{4,9,0,1}, '{5,8,12,1}, '{5,9,0,1}, '{6,8,12,1}, '{6,9,0,1},
                '{7,8,12,1}, '{7,9,0,1}, '{8,8,12,1}, '{8,9,0,1}};
      exp_tab = '{'{0,8,15,0}, '{1,7,11,0}, '{1,10,13,1}, '{2,25,20,0},
                  '{4,8,12,0}, '{5,8,12,0}, '{7,8,12,0}};

      repeat (2) @(posedge clk_in);
      #1;
      chk("rst burst_active", burst_active_out, 0);
      chk("rst burst_start", burst_start_out, 0);
      chk("rst listening", listening_out, 0);
      chk("rst ping_done", ping_done_out, 0);
      chk("rst overflow", overflow_out, 0);
      chk("rst valid", res.result_valid_out, 0);
      chk("rst angle", beam_angle_out, -30);
      rst_in = 1'b0;
      step(); step();
      chk("idle without enable", burst_active_out, 0);
      enable_in = 1'b1;
      step();

      for (int p = 0; p < 8; p++) begin
         begin_ping(p);
         if (p == 0)
            foreach (tv[i]) begin
               run_to(tv[i].t);
               chk($sformatf("t%0d burst_start", tv[i].t), burst_start_out, tv[i].bs);
               chk($sformatf("t%0d burst_active", tv[i].t), burst_active_out, tv[i].ba);
               chk($sformatf("t%0d listening", tv[i].t), listening_out, tv[i].li);
               chk($sformatf("t%0d ping_done", tv[i].t), ping_done_out, tv[i].pd);
            end
         if (p == 4) res.result_ready_in = 1'b0;
         if (p == 5) begin
            run_to(5);
            chk("p5 overflow clear", overflow_out, 0);
            run_to(11);
            chk("p5 head angle", $signed(res.result_angle_out), exp_angle(4));
            chk("p5 head tof", res.result_tof_out, 8);
         end
         if (p == 6) begin
            run_to(11);
            chk("p6 overflow", overflow_out, 1);
            chk("p6 valid", res.result_valid_out, 1);
            chk("p6 head angle", $signed(res.result_angle_out), exp_angle(4));
         end
         if (p == 7) begin
            run_to(10);
            res.result_ready_in = 1'b1;
            run_to(15);
            enable_in = 1'b0;
            run_to(20);
            chk("p7 listen after disable", listening_out, 1);
         end
         run_to(26);
         chk($sformatf("p%0d ping_done", p), ping_done_out, 1);
         chk($sformatf("p%0d angle held", p), beam_angle_out, exp_angle(p));
         run_to(27);
      end

      chk("idle after disable", burst_active_out, 0);
      chk("idle no burst_start", burst_start_out, 0);
      step();
      enable_in = 1'b1;
      step();
      begin_ping(8);
      res.result_ready_in = 1'b0;
      run_to(15);
      chk("p8 valid before reset", res.result_valid_out, 1);
      chk("p8 listening", listening_out, 1);
      rst_in = 1'b1;
      #1;
      chk("mid rst burst_active", burst_active_out, 0);
      chk("mid rst listening", listening_out, 0);
      chk("mid rst ping_done", ping_done_out, 0);
      chk("mid rst overflow", overflow_out, 0);
      chk("mid rst valid", res.result_valid_out, 0);
      chk("mid rst angle", beam_angle_out, -30);
      chk("mid rst result tof", res.result_tof_out, 0);
      enable_in = 1'b0;
      step();
      rst_in = 1'b0;
      step(); step();
      chk("post rst idle", burst_active_out, 0);
      chk("scoreboard drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/sweep_ping_controller.md
Name: sweep_ping_controller

Overview:
Next-generation ping sequencer for the sonar array. It steps the beam angle across a programmable sweep and times each burst/blanking/listen window. During listen it detects up to MAX_ECHOES echoes per ping from the aggregated receive magnitude, using a threshold with hysteresis. Each echo (angle, time of flight, peak) is queued in a result FIFO with valid/ready output toward the range/display logic. It replaces the fixed single-angle pulse timing and single-echo flag.

Parameters:
BURST_CYCLES, 524288, transmit burst length in clocks
BLANK_CYCLES, 65536, post-burst ring-down window; samples ignored
LISTEN_CYCLES, 16252928, echo acceptance window in clocks
ANGLE_WIDTH, 7, signed beam angle width
ANGLE_MIN, -30, first sweep angle (degrees)
ANGLE_MAX, 30, last sweep angle
ANGLE_STEP, 10, positive angle increment per ping
SAMPLE_WIDTH, 16, unsigned magnitude width
HYST, 256, echo release hysteresis below threshold
MAX_ECHOES, 4, echoes recorded per ping
FIFO_DEPTH, 8, result FIFO entries (power of 2)
TOF_WIDTH, $clog2(BURST_CYCLES+BLANK_CYCLES+LISTEN_CYCLES), time-of-flight width

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset
enable_in  input  1  run sweep
threshold_in  input  SAMPLE_WIDTH  echo detect threshold
sample_in  input  SAMPLE_WIDTH  aggregated receive magnitude
sample_valid_in  input  1  sample_in qualifier
beam_angle_out  output  ANGLE_WIDTH signed  current steering angle
burst_start_out  output  1  one-cycle pulse on first burst cycle
burst_active_out  output  1  high during BURST
listening_out  output  1  high during LISTEN
ping_done_out  output  1  one-cycle pulse in ADVANCE
result_valid_out  output  1  FIFO non-empty
result_ready_in  input  1  consumer accepts head entry
result_angle_out  output  ANGLE_WIDTH  angle of head entry
result_tof_out  output  TOF_WIDTH  clocks from burst start to threshold crossing
result_peak_out  output  SAMPLE_WIDTH  max magnitude within echo
result_index_out  output  $clog2(MAX_ECHOES)  echo ordinal within its ping
overflow_out  output  1  sticky: result dropped because FIFO full

Behaviour:
- Clock and reset: one clock, clk_in. Reset rst_in is asynchronous and active-high.
- Reset values: all outputs 0, except beam_angle_out = ANGLE_MIN. FIFO empties; state IDLE.
- FSM: IDLE -> BURST when enable_in is high.
  - BURST lasts BURST_CYCLES, then BLANK lasts BLANK_CYCLES, then LISTEN lasts LISTEN_CYCLES, then ADVANCE lasts 1 cycle.
  - ADVANCE -> BURST if enable_in is high, else IDLE. Ping period = BURST+BLANK+LISTEN+1.
  - Deasserting enable_in mid-ping does not abort the ping.
- tof counter: 0 on first BURST cycle, +1 every clock, held by state; no wrap within a ping.
- burst_start_out is high exactly on the first BURST cycle. burst_active_out and listening_out are registered state decodes.
- Angle stepping:
  - beam_angle_out is constant for a whole ping and updates in ADVANCE.
  - next = cur + ANGLE_STEP; if next > ANGLE_MAX, next = ANGLE_MIN.
  - Signed arithmetic is computed one bit wider to avoid overflow.
- Echo detector: acts only on sample_valid_in during LISTEN.
  - Armed when sample_in >= threshold_in: open echo, capture tof and peak = sample.
  - While open: peak = max(peak, sample).
  - Close when sample_in < threshold_in - HYST, saturated at 0. Push the result the cycle after the closing sample.
  - An echo still open when LISTEN ends is pushed in ADVANCE with its partial peak.
  - After MAX_ECHOES pushes in a ping, further crossings are ignored. Index resets each ping.
- Result FIFO:
  - Push when not full. Pop when result_valid_out && result_ready_in.
  - Simultaneous push and pop on a full FIFO succeeds without loss.
  - Push while full (and no pop): entry dropped, overflow_out set until reset.
  - Head outputs are stable while result_valid_out is high and not popped.
- Reset mid-ping: immediate return to IDLE, FIFO cleared, angle = ANGLE_MIN.

Optional Feature:
- Macro SWEEP_BOUNCE_EN.
- Defined: ping-pong sweep. Direction reverses at the ends (ANGLE_MIN..ANGLE_MAX..ANGLE_MIN); end angles are not repeated; a direction bit resets to ascending.
- Undefined: wrap sweep as above.

Test Plan:
All scenarios use BURST=4, BLANK=2, LISTEN=20, HYST=2, threshold_in=10, MAX_ECHOES=2, FIFO_DEPTH=2.
- Reset, then enable_in=1 -> burst_start_out pulses at cycle 0. burst_active_out high for cycles 0-3, listening_out high for cycles 6-25, ping_done_out at cycle 26, next burst_start_out at cycle 27.
- Four pings, no samples -> beam_angle_out = -30, -20, -10, 0, then +10 for the fifth ping. After 30, returns to -30 (bounce build: 20).
- Samples 12,15,9,7 at tof 8-11 -> one result: angle=-30, tof=8, peak=15, index=0. The sample of 9 does not close the echo (hysteresis); the sample of 7 does.
- Three separate above-threshold bursts in one ping -> only index 0 and 1 are queued.
- result_ready_in=0 across three pings, each with one echo -> FIFO holds the first two results and overflow_out=1. The head entry is unchanged until popped.
- Echo open at last LISTEN cycle (sample=20) -> entry with peak=20 pushed in ADVANCE. Asserting rst_in mid-LISTEN -> all outputs 0, angle -30, result_valid_out=0.
